// File: rtl/crank_pkg.sv
// crank_pkg: shared types and constants for the crank sensor receive path.
//   state_e        FSM states of crank_meter
//   RPM_NUMERATOR  ms per minute, divided by the crank period in ms
//   PERIOD_W       width of the millisecond period timer
//   CADENCE_W/MAX  width and saturation value of the cadence output
//   sat_cadence()  clamps a divider quotient to the cadence range
package crank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_e;

    localparam int RPM_NUMERATOR = 60000;
    localparam int DIVIDEND_W    = 16;
    localparam int PERIOD_W      = 12;
    localparam int CADENCE_W     = 8;
    localparam int CADENCE_MAX   = 255;
    localparam int COUNT_W       = 16;

    function automatic logic [CADENCE_W-1:0] sat_cadence(input logic [DIVIDEND_W-1:0] q);
        if (q > DIVIDEND_W'(CADENCE_MAX)) begin
            return CADENCE_W'(CADENCE_MAX);
        end
        return q[CADENCE_W-1:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   core_CLK, core_Reset   clock, synchronous active-high reset
//   start                  load dividend/divisor (ignored while busy)
//   dividend, divisor      operands sampled on start
//   busy                   high for DIVIDEND_W cycles after start
//   done                   one-cycle pulse during the final step
//   quotient               result, valid while done is high
// A divisor of zero yields an all-ones quotient; callers avoid it.
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 12
) (
    input  logic                  core_CLK,
    input  logic                  core_Reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    trial;

    // quo_q doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done    = 1'b0;
        shifted = {rem_q, quo_q[DIVIDEND_W-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (busy_q) begin
            // remainder < divisor, so the shifted value is below 2*divisor and
            // the borrow bit alone tells whether the subtraction fits
            if (!trial[DIVISOR_W]) begin
                rem_d = trial[DIVISOR_W-1:0];
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[DIVISOR_W-1:0];
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(DIVIDEND_W);
            busy_d = 1'b1;
        end
    end

    assign quotient = quo_d;
    assign busy     = busy_q;

    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/crank_meter.sv
// crank_meter: crank sensor receiver. Synchronises and debounces nCrank,
// times falling-edge intervals in ms and converts them to RPM.
//   core_CLK       system clock (CLK_HZ)
//   core_Reset     synchronous reset, active-high
//   nCrank         asynchronous crank pulse, active-low, one per revolution
//   cadence        RPM, saturating at 255, holds between strobes
//   cadence_valid  one-cycle strobe on each cadence update
//   crank_count    revolutions since reset, wrapping
//   busy           divider in progress
// Build option: define CRANK_AVG_EN to divide by the average of the last
// four accepted periods instead of the latest one.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no reference edge yet (after reset or timeout)
// MEASURE | timing the interval since the last edge
// DIVIDE  | converting a latched period to RPM; further edges only counted
module crank_meter
    import crank_pkg::*;
#(
    parameter int CLK_HZ          = 1000000,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int TIMEOUT_MS      = 3000
) (
    input  logic                 core_CLK,
    input  logic                 core_Reset,
    input  logic                 nCrank,
    output logic [CADENCE_W-1:0] cadence,
    output logic                 cadence_valid,
    output logic [COUNT_W-1:0]   crank_count,
    output logic                 busy
);

    localparam int PRESC_MAX = CLK_HZ / 1000 - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 deb_q, deb_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 crank_edge_q, crank_edge_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    state_e               state_q, state_d;
    logic [CADENCE_W-1:0] cadence_q, cadence_d;
    logic                 valid_q, valid_d;

    logic                 ms_tick;
    logic                 timeout_evt;
    logic                 div_start;
    logic                 div_busy;
    logic                 div_done;
    logic [DIVIDEND_W-1:0] div_quotient;
    logic [PERIOD_W-1:0]  divisor;

    // Input conditioning: the level flips only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; crank_edge is registered so all
    // downstream logic sees a clean single-cycle pulse.
    always_comb begin
        sync1_d   = nCrank;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        crank_edge_d = deb_q & ~deb_d;
    end

    // Timebase and revolution counter; an edge restarts the period.
    assign ms_tick = (presc_q == PRESC_W'(PRESC_MAX));

    always_comb begin
        presc_d  = presc_q;
        period_d = period_q;
        count_d  = count_q;
        if (crank_edge_q) begin
            presc_d  = '0;
            period_d = '0;
            count_d  = count_q + COUNT_W'(1);
        end else begin
            presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);
            if (ms_tick && (period_q != '1)) begin
                period_d = period_q + PERIOD_W'(1);
            end
        end
    end

    // The tick that would carry period_ms to TIMEOUT_MS fires the timeout;
    // a coincident edge takes priority.
    assign timeout_evt = (state_q == MEASURE) && !crank_edge_q && ms_tick &&
                         (period_q == PERIOD_W'(TIMEOUT_MS - 1));

    always_comb begin
        state_d   = state_q;
        cadence_d = cadence_q;
        valid_d   = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (crank_edge_q) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (crank_edge_q) begin
                    if (period_q == '0) begin
                        cadence_d = CADENCE_W'(CADENCE_MAX);
                        valid_d   = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIVIDE;
                    end
                end else if (timeout_evt) begin
                    cadence_d = '0;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    cadence_d = sat_cadence(div_quotient);
                    valid_d   = 1'b1;
                    state_d   = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CRANK_AVG_EN
    // hist_q holds the three previously accepted periods; together with the
    // period being accepted now they form the four-entry window.
    logic [PERIOD_W-1:0]   hist_q [3];
    logic [PERIOD_W-1:0]   hist_d [3];
    logic [1:0]            hist_cnt_q, hist_cnt_d;
    logic [PERIOD_W:0]     sum2;
    logic [PERIOD_W+1:0]   sum4;

    always_comb begin
        sum2 = {1'b0, period_q} + {1'b0, hist_q[0]};
        sum4 = {2'b00, period_q} + {2'b00, hist_q[0]} +
               {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        // with three periods available, the oldest is dropped so the average
        // stays a shift rather than a divide by three
        case (hist_cnt_q)
            2'd0:       divisor = period_q;
            2'd1, 2'd2: divisor = sum2[PERIOD_W:1];
            default:    divisor = sum4[PERIOD_W+1:2];
        endcase
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        if (timeout_evt) begin
            hist_d     = '{default: '0};
            hist_cnt_d = '0;
        end else if (div_start) begin
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = period_q;
            if (hist_cnt_q != 2'd3) begin
                hist_cnt_d = hist_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            hist_q     <= '{default: '0};
            hist_cnt_q <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end
`else
    assign divisor = period_q;
`endif

    seq_divider #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (PERIOD_W)
    ) u_div (
        .core_CLK   (core_CLK),
        .core_Reset (core_Reset),
        .start      (div_start),
        .dividend   (DIVIDEND_W'(RPM_NUMERATOR)),
        .divisor    (divisor),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quotient)
    );

    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            deb_q        <= 1'b1;
            deb_cnt_q    <= '0;
            crank_edge_q <= 1'b0;
            presc_q      <= '0;
            period_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            cadence_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            crank_edge_q <= crank_edge_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cadence_q    <= cadence_d;
            valid_q      <= valid_d;
        end
    end

    assign cadence       = cadence_q;
    assign cadence_valid = valid_q;
    assign crank_count   = count_q;
    assign busy          = div_busy;

endmodule

// File: doc/crank_meter.md
Name: crank_meter

Overview:
- Receive end of the crank sensor interface. Consumes the active-low nCrank pulse train, from the reed switch or the crank pulse generator, and produces the cadence in RPM plus a revolution count for the display/mode logic.
- Processing chain: synchronise and debounce the input, time the interval between falling edges in milliseconds, then divide that interval into 60000 with a sequential divider.

Parameters:
- CLK_HZ, 1000000, core_CLK frequency; ms tick every CLK_HZ/1000 cycles.
- DEBOUNCE_CYCLES, 64, consecutive stable synchronised samples needed to accept a level change.
- TIMEOUT_MS, 3000, interval after which cadence is forced to 0. Must be ≤ 4095.

Ports:
- core_CLK  in  1  system clock
- core_Reset  in  1  synchronous reset, active-high
- nCrank  in  1  asynchronous crank pulse, active-low, one low pulse per revolution
- cadence  out  8  RPM, saturating at 255
- cadence_valid  out  1  one-cycle strobe when cadence is updated
- crank_count  out  16  revolutions since reset, wraps 65535→0
- busy  out  1  divider in progress

Behaviour:
- Reset (core_Reset high at a clock edge):
  - cadence=0, cadence_valid=0, crank_count=0, busy=0.
  - Sync flops=1, debounced level=1, ms prescaler=0, period_ms=0, state=IDLE.
  - Reset mid-divide abandons the division; no strobe is issued.
- Input conditioning:
  - 2-flop synchroniser feeds the debouncer.
  - The debounced level takes the synchronised value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any re-agreement clears the debounce counter.
  - crank_edge is a one-cycle pulse on a debounced 1→0 transition.
- Timebase:
  - Prescaler wraps at CLK_HZ/1000-1 and emits ms_tick.
  - period_ms (12 bit) increments on ms_tick and saturates at 4095.
- On crank_edge, in every state:
  - crank_count += 1.
  - period_ms and the prescaler clear to 0 in the same cycle.
- States:
  - IDLE: no reference edge. crank_edge → MEASURE, with no cadence update.
  - MEASURE:
    - crank_edge with latched period P=0 → cadence=255, strobe, stay in MEASURE.
    - crank_edge with P>0 → load divider (60000/P), busy=1 → DIVIDE.
    - period_ms reaches TIMEOUT_MS (on that tick) → cadence=0, strobe, → IDLE.
  - DIVIDE:
    - Restoring divider, 16-bit dividend, 12-bit divisor, 1 quotient bit per cycle, 16 cycles.
    - On completion: cadence = min(quotient, 255), strobe, busy=0 → MEASURE.
    - Latency is 17 cycles from crank_edge to cadence_valid.
    - crank_edge during DIVIDE: counted and the timer restarts, but the new period is discarded (the divide in flight finishes).
    - Timeout cannot occur in DIVIDE, because DIVIDE lasts far less than 1 ms.
- cadence holds its value between strobes.

Optional Feature:
- CRANK_AVG_EN defined:
  - Keep the last 4 accepted periods in a shift register; the divisor is their sum>>2.
  - The register is cleared on reset and on timeout.
  - Until 4 periods are captured, the average is taken over those available: 1 → P, 2 → sum>>1, 3 → sum/3 via a 3-entry table-free path is not allowed, so use the last 2 instead.
- CRANK_AVG_EN undefined: divisor = latest P only; no shift register.

Decomposition:
- crank_pkg:
  - state enum {IDLE, MEASURE, DIVIDE}.
  - RPM_NUMERATOR=60000.
  - PERIOD_W=12, CADENCE_W=8, CADENCE_MAX=255.
- Sub-module seq_divider (start/busy/done, dividend/divisor/quotient), reusable later for speed = wheel_circumference/period.

Test Plan (CLK_HZ=10000, i.e. 10 cycles/ms; DEBOUNCE_CYCLES=4):
1. Reset, then 3 falling edges 500 ms apart → first edge gives no strobe; edges 2 and 3 each give cadence=120 with cadence_valid 17 cycles after crank_edge; crank_count=3.
2. Edges 1000 ms apart, then edges 100 ms apart → cadence 60, then 255 (600 saturated).
3. After cadence=60, hold nCrank high → at 3000 ms after the last edge, cadence=0 with one strobe; the next edge gives no strobe (IDLE).
4. 2-cycle low glitch on nCrank → no crank_edge, crank_count unchanged. 10-cycle low pulse → counted.
5. Assert core_Reset 5 cycles into DIVIDE → no strobe; all outputs 0 on the next cycle; busy=0.
6. With CRANK_AVG_EN, periods 400,600,400,600 ms → after the 4th edge cadence=120 (average 500 ms).
